// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: parser states, trace character codes, format and error encodings
package cpu_trace_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_TIME, S_PC, S_COLON, S_SP1, S_GRF, S_ADDR,
        S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
    } state_t;
    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_SP     = 8'h20;
    localparam logic [1:0] FMT_REG = 2'b01;
    localparam logic [1:0] FMT_MEM = 2'b10;
    localparam int ERR_TIME = 0;
    localparam int ERR_PC   = 1;
    localparam int ERR_ADDR = 2;
    localparam int ERR_GRF  = 3;
    localparam int ERR_ZERO = 4;
endpackage

// File: rtl/trace_char_class.sv
// trace_char_class: classifies an ASCII character as decimal / lowercase hex digit
module trace_char_class (
    input  logic [7:0] c,
    output logic       is_dec,
    output logic       is_hex,
    output logic [3:0] hex_val
);
    // digit ranges; 'a'..'f' have low nibble 1..6, so +9 maps them to 10..15
    always_comb begin
        is_dec  = c >= 8'h30 && c <= 8'h39;
        is_hex  = is_dec || (c >= 8'h61 && c <= 8'h66);
        hex_val = is_dec ? c[3:0] : c[3:0] + 4'd9;
    end
endmodule

// File: rtl/cpu_trace_checker.sv
// cpu_trace_checker: parses write-back trace records and flags format/range errors
module cpu_trace_checker
    import cpu_trace_pkg::*;
#(
    parameter logic [31:0] PC_LO       = 32'h0000_3000,
    parameter logic [31:0] PC_HI       = 32'h0000_4fff,
    parameter logic [31:0] ADDR_HI     = 32'h0000_2fff,
    parameter int unsigned NUM_REGS    = 32,
    parameter int unsigned TIME_DIGITS = 4,
    parameter int unsigned GRF_DIGITS  = 4,
    parameter int unsigned TIME_W      = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             char_valid,
    input  logic [7:0]       char,
    input  logic [15:0]      freq,
    output logic             rec_valid,
    output logic [1:0]       format_type,
    output logic [4:0]       error_code,
    output logic [CNT_W-1:0] rec_count,
    output logic [CNT_W-1:0] err_count
);
    state_t state, nxt_state;
    logic [31:0] cnt, nxt_cnt, pc, nxt_pc, addr, nxt_addr, data, nxt_data;
    logic [TIME_W-1:0] time_acc, nxt_time;
    logic [15:0] grf, nxt_grf, half;
    logic is_mem, nxt_mem, done, is_dec, is_hex;
    logic [3:0] hex_val;
    logic [4:0] err;

    trace_char_class u_class (.c(char), .is_dec(is_dec), .is_hex(is_hex), .hex_val(hex_val));

    // next-state and accumulator update for one accepted character
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_time  = time_acc;
        nxt_pc    = pc;
        nxt_addr  = addr;
        nxt_data  = data;
        nxt_grf   = grf;
        nxt_mem   = is_mem;
        done      = 1'b0;
        if (char_valid) begin
            if (char == CH_CARET) begin
                nxt_state = S_TIME;
                nxt_cnt   = '0;
                nxt_time  = '0;
                nxt_pc    = '0;
                nxt_addr  = '0;
                nxt_data  = '0;
                nxt_grf   = '0;
                nxt_mem   = 1'b0;
            end else begin
                nxt_state = S_IDLE;
                case (state)
                    S_TIME: begin
                        if (is_dec && cnt < TIME_DIGITS) begin
                            nxt_state = S_TIME;
                            nxt_time  = time_acc * TIME_W'(10) + TIME_W'(char[3:0]);
                            nxt_cnt   = cnt + 32'd1;
                        end else if (char == CH_AT && cnt != 0) begin
                            nxt_state = S_PC;
                            nxt_cnt   = '0;
                        end
                    end
                    S_PC: if (is_hex) begin
                        nxt_pc    = {pc[27:0], hex_val};
                        nxt_cnt   = cnt + 32'd1;
                        nxt_state = cnt == 32'd7 ? S_COLON : S_PC;
                    end
                    S_COLON: nxt_state = char == CH_COLON ? S_SP1 : S_IDLE;
                    S_SP1: begin
                        nxt_state = char == CH_SP ? S_SP1 : char == CH_DOLLAR ? S_GRF :
                                    char == CH_STAR ? S_ADDR : S_IDLE;
                        nxt_mem   = char == CH_STAR;
                        nxt_cnt   = '0;
                    end
                    S_GRF: begin
                        if (is_dec && cnt < GRF_DIGITS) begin
                            nxt_state = S_GRF;
                            nxt_grf   = grf * 16'd10 + {12'd0, char[3:0]};
                            nxt_cnt   = cnt + 32'd1;
                        end else if (cnt != 0) begin
                            nxt_state = char == CH_SP ? S_SP2 : char == CH_LT ? S_EQ : S_IDLE;
                        end
                    end
                    S_ADDR: if (is_hex) begin
                        nxt_addr  = {addr[27:0], hex_val};
                        nxt_cnt   = cnt + 32'd1;
                        nxt_state = cnt == 32'd7 ? S_SP2 : S_ADDR;
                    end
                    S_SP2, S_LT: nxt_state = char == CH_SP ? S_SP2 : char == CH_LT ? S_EQ : S_IDLE;
                    S_EQ: nxt_state = char == CH_EQ ? S_SP3 : S_IDLE;
                    S_SP3: begin
                        nxt_state = char == CH_SP ? S_SP3 : is_hex ? S_DATA : S_IDLE;
                        nxt_data  = is_hex ? {data[27:0], hex_val} : data;
                        nxt_cnt   = 32'd1;
                    end
                    S_DATA: if (is_hex) begin
                        nxt_data  = {data[27:0], hex_val};
                        nxt_cnt   = cnt + 32'd1;
                        nxt_state = cnt == 32'd7 ? S_HASH : S_DATA;
                    end
                    S_HASH: done = char == CH_HASH;
                    default: nxt_state = S_IDLE;
                endcase
            end
        end
    end

    // error flags from the fully accumulated record, used on the '#' edge
    always_comb begin
        half           = (freq >> 1) - 16'd1;
        err            = '0;
        err[ERR_TIME]  = |(time_acc & TIME_W'(half));
        err[ERR_PC]    = pc < PC_LO || pc > PC_HI || pc[1:0] != 2'b00;
        err[ERR_ADDR]  = is_mem && (addr > ADDR_HI || addr[1:0] != 2'b00);
        err[ERR_GRF]   = !is_mem && {16'd0, grf} >= NUM_REGS;
        err[ERR_ZERO]  = !is_mem && grf == 16'd0 && data != 32'd0;
    end

    // parser state and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            time_acc <= '0;
            pc       <= '0;
            addr     <= '0;
            data     <= '0;
            grf      <= '0;
            is_mem   <= 1'b0;
        end else begin
            state    <= nxt_state;
            cnt      <= nxt_cnt;
            time_acc <= nxt_time;
            pc       <= nxt_pc;
            addr     <= nxt_addr;
            data     <= nxt_data;
            grf      <= nxt_grf;
            is_mem   <= nxt_mem;
        end
    end

    // one-cycle result pulse and saturating counters
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_valid   <= 1'b0;
            format_type <= '0;
            error_code  <= '0;
            rec_count   <= '0;
            err_count   <= '0;
        end else begin
            rec_valid   <= done;
            format_type <= done ? (is_mem ? FMT_MEM : FMT_REG) : 2'b00;
            error_code  <= done ? err : 5'd0;
            if (done && rec_count != '1) rec_count <= rec_count + 1'b1;
            if (done && err != 5'd0 && err_count != '1) err_count <= err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_cpu_trace_checker.sv
// tb_cpu_trace_checker: directed trace records with hand-computed results
module tb_cpu_trace_checker;
    logic clk = 1'b0, reset = 1'b1, char_valid = 1'b0;
    logic [7:0] chr = 8'h00;
    logic [15:0] freq = 16'd4;
    logic rec_valid, rv2;
    logic [1:0] format_type, ft2;
    logic [4:0] error_code, ec2;
    logic [15:0] rec_count, err_count;
    logic [1:0] rc2, errc2;
    int n_cmp = 0, n_fail = 0, exp_rec = 0, exp_err = 0, pulses = 0, exp_pulses = 0;

    always #5 clk = ~clk;

    cpu_trace_checker dut (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(chr), .freq(freq),
        .rec_valid(rec_valid), .format_type(format_type), .error_code(error_code),
        .rec_count(rec_count), .err_count(err_count)
    );

    cpu_trace_checker #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .char_valid(char_valid), .char(chr), .freq(freq),
        .rec_valid(rv2), .format_type(ft2), .error_code(ec2),
        .rec_count(rc2), .err_count(errc2)
    );

    always @(negedge clk) if (rec_valid) pulses++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        chr = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chr = 8'h5e;
            char_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({rec_valid, format_type, error_code, rec_count, err_count} !== 40'd0) begin n_fail++; $display("FAIL reset outputs got %h want 0", {rec_valid, format_type, error_code, rec_count, err_count}); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reg_clean;
        send_str("^10@00003000: $5 <= 0000000a#");
        exp_rec++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_01_00000) begin n_fail++; $display("FAIL reg_clean result got %b want 1_01_00000", {rec_valid, format_type, error_code}); end
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL reg_clean counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
        idle(1);
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'd0) begin n_fail++; $display("FAIL reg_clean fall got %b want 0", {rec_valid, format_type, error_code}); end
    endtask

    task automatic test_mem_errors;
        send_str("^7@00003002: *00003000 <= 12345678#");
        exp_rec++; exp_err++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_10_00111) begin n_fail++; $display("FAIL mem_errors result got %b want 1_10_00111", {rec_valid, format_type, error_code}); end
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL mem_errors counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
    endtask

    task automatic test_reg_errors;
        send_str("^8@00004ffc: $0 <= 00000001#");
        exp_rec++; exp_err++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_01_10000) begin n_fail++; $display("FAIL grf_zero result got %b want 1_01_10000", {rec_valid, format_type, error_code}); end
        send_str("^8@00003000:$40<=00000000#");
        exp_rec++; exp_err++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_01_01000) begin n_fail++; $display("FAIL grf_range result got %b want 1_01_01000", {rec_valid, format_type, error_code}); end
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL reg_errors counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
    endtask

    task automatic test_bounds;
        freq = 16'd16;
        send_str("^24@00005000: *00002ffc <= 00000000#");
        exp_rec++; exp_err++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_10_00010) begin n_fail++; $display("FAIL pc_high result got %b want 1_10_00010", {rec_valid, format_type, error_code}); end
        send_str("^20@00002ffc: $31 <= 00000000#");
        exp_rec++; exp_err++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_01_00011) begin n_fail++; $display("FAIL pc_low_time result got %b want 1_01_00011", {rec_valid, format_type, error_code}); end
        freq = 16'd4;
    endtask

    task automatic test_malformed;
        send_str("^10@0000300: $5 <= 0000000a#");
        send_str("^10@00003000: $5 <= 0000000A#");
        send_str("^12345@00003000: $5 <= 0000000a#");
        send_str("^10@00003000: $5 < 0000000a#");
        idle(2);
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL malformed counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
        n_cmp++; if (pulses !== exp_pulses) begin n_fail++; $display("FAIL malformed pulses got %0d want %0d", pulses, exp_pulses); end
    endtask

    task automatic test_restart;
        send_str("^10@00003000: $5 <= 00");
        send_str("^12@00003000: *00000100 <= deadbeef#");
        exp_rec++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_10_00000) begin n_fail++; $display("FAIL restart result got %b want 1_10_00000", {rec_valid, format_type, error_code}); end
        idle(1);
        n_cmp++; if (pulses !== exp_pulses || rec_count !== 16'(exp_rec)) begin n_fail++; $display("FAIL restart pulses got %0d/%0d want %0d/%0d", pulses, rec_count, exp_pulses, exp_rec); end
    endtask

    task automatic test_stall;
        send_str("^9@00003004: $31");
        idle(3);
        send_str(" <= 00000000#");
        exp_rec++; exp_err++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_01_00001) begin n_fail++; $display("FAIL stall result got %b want 1_01_00001", {rec_valid, format_type, error_code}); end
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL stall counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
    endtask

    task automatic test_back_to_back;
        send_str("^2@00003000: $1 <= 00000000#");
        exp_rec++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_01_00000) begin n_fail++; $display("FAIL b2b first got %b want 1_01_00000", {rec_valid, format_type, error_code}); end
        send(8'h5e);
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'd0) begin n_fail++; $display("FAIL b2b gap got %b want 0", {rec_valid, format_type, error_code}); end
        send_str("4@00003ffc: *00002ffc <= ffffffff#");
        exp_rec++; exp_pulses++;
        n_cmp++; if ({rec_valid, format_type, error_code} !== 8'b1_10_00000) begin n_fail++; $display("FAIL b2b second got %b want 1_10_00000", {rec_valid, format_type, error_code}); end
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL b2b counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
    endtask

    task automatic test_reset_mid;
        send_str("^2@00003000: $1 <= 00000000#");
        exp_pulses++;
        @(negedge clk);
        reset = 1'b1; chr = 8'h5e; char_valid = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({rec_valid, format_type, error_code, rec_count, err_count} !== 40'd0) begin n_fail++; $display("FAIL reset_mid outputs got %h want 0", {rec_valid, format_type, error_code, rec_count, err_count}); end
        @(negedge clk);
        reset = 1'b0; char_valid = 1'b0;
        exp_rec = 0; exp_err = 0;
        send_str("2@00003000: $1 <= 00000000#");
        send_str("^2@00003000: $1 <= 0000");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        send_str("0000#");
        idle(1);
        n_cmp++; if (rec_count !== 16'd0 || err_count !== 16'd0 || pulses !== exp_pulses) begin n_fail++; $display("FAIL reset_mid discard got %0d/%0d/%0d want 0/0/%0d", rec_count, err_count, pulses, exp_pulses); end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rec = 0; exp_err = 0;
        for (int i = 0; i < 5; i++) begin
            send_str("^7@00003000: $1 <= 00000000#");
            exp_rec++; exp_err++; exp_pulses++;
        end
        n_cmp++; if ({rv2, ft2, ec2} !== 8'b1_01_00001) begin n_fail++; $display("FAIL sat result got %b want 1_01_00001", {rv2, ft2, ec2}); end
        n_cmp++; if (rc2 !== 2'd3 || errc2 !== 2'd3) begin n_fail++; $display("FAIL sat counts got %0d/%0d want 3/3", rc2, errc2); end
        n_cmp++; if (rec_count !== 16'(exp_rec) || err_count !== 16'(exp_err)) begin n_fail++; $display("FAIL sat wide counts got %0d/%0d want %0d/%0d", rec_count, err_count, exp_rec, exp_err); end
    endtask

    initial begin
        test_reset;
        test_reg_clean;
        test_mem_errors;
        test_reg_errors;
        test_bounds;
        test_malformed;
        test_restart;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        test_saturation;
        idle(2);
        n_cmp++; if (pulses !== exp_pulses) begin n_fail++; $display("FAIL total pulses got %0d want %0d", pulses, exp_pulses); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_trace_checker.md
# cpu_trace_checker

Parametrised streaming checker for the CPU write-back trace. One character arrives per accepted cycle. The block parses register-write records (`^time@pc: $grf <= data#`) and memory-write records (`^time@pc: *addr <= data#`). For each well-formed record it emits a one-cycle result with format and error flags, and keeps saturating record and error counters. It sits on the testbench/UART side of the CPU, after the trace serialiser.

## Interface
- `PC_LO`, default 32'h0000_3000: lowest legal PC.
- `PC_HI`, default 32'h0000_4fff: highest legal PC.
- `ADDR_HI`, default 32'h0000_2fff: highest legal memory address.
- `NUM_REGS`, default 32: legal GRF indices are 0..NUM_REGS-1.
- `TIME_DIGITS`, default 4: maximum number of decimal digits in time.
- `GRF_DIGITS`, default 4: maximum number of decimal digits in grf.
- `TIME_W`, default 16: width of the time accumulator.
- `CNT_W`, default 16: width of the counters.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `char_valid`, in, 1: `char` is consumed on this edge only when high.
- `char`, in, 8: ASCII character.
- `freq`, in, 16: tick divisor. Must be a power of two, ≥2, and stable during a record.
- `rec_valid`, out, 1: one-cycle pulse marking a complete, well-formed record.
- `format_type`, out, 2: 01 = register record, 10 = memory record, 00 when `rec_valid` is low.
- `error_code`, out, 5: error flags, all zero when `rec_valid` is low.
- `rec_count`, out, CNT_W: number of well-formed records (saturating).
- `err_count`, out, CNT_W: number of well-formed records with a nonzero error code (saturating).

## Operation
- Parser states and transitions:
  - IDLE
  - TIME: 1..TIME_DIGITS decimal digits, then `@`.
  - PC: exactly 8 lowercase hex digits.
  - COLON: `:`.
  - SP1: zero or more spaces, then `$` goes to GRF, or `*` goes to ADDR.
  - GRF: 1..GRF_DIGITS decimal digits.
  - ADDR: exactly 8 hex digits.
  - SP2: zero or more spaces.
  - LT: `<`.
  - EQ: `=`.
  - SP3: zero or more spaces.
  - DATA: exactly 8 hex digits.
  - HASH: `#`.
- `^` accepted in any state, including inside a record, clears the accumulators and enters TIME.
- Any other unexpected character, or a digit that exceeds a field's length limit, returns the parser to IDLE. No result is produced for that record.
- Hex digits are 0-9 and a-f only; uppercase is a format error.
- Accumulators: time is taken modulo 2^TIME_W; pc, addr and data are 32 bits; grf is 16 bits. Decimal accumulation is x*10 + d.
- Error bits, evaluated on the `#` edge:
  - [0] `(time & ((freq>>1)-1)) != 0`
  - [1] pc outside [PC_LO, PC_HI] or pc[1:0] != 0
  - [2] memory record only: addr > ADDR_HI or addr[1:0] != 0
  - [3] register record only: grf ≥ NUM_REGS
  - [4] register record only: grf == 0 and data != 0
- Counters: `rec_count` increments on every result. `err_count` increments when `error_code` != 0. Both hold at 2^CNT_W-1.

## Timing
- On reset, every output is 0, the parser goes to IDLE, and `char` is ignored on the reset edge. Reset in the middle of a record discards that record.
- When `char_valid` is low, the parser and accumulators hold. `rec_valid` still falls after exactly one cycle.
- Latency: if `#` is accepted at edge k, then `rec_valid`, `format_type` and `error_code` are high/valid from edge k until edge k+1. The counters update at edge k.
- Back-to-back: a `^` at edge k+1 starts a new record with no lost cycle. The result of the previous record still deasserts at edge k+1.
- All outputs are registered. There is no combinational path from `char` to any output.

## Structure
- `cpu_trace_pkg` holds:
  - the parser state enum;
  - character constants for `^ @ : $ * < = #` and space;
  - `FMT_REG`, `FMT_MEM`;
  - the `ERR_TIME`, `ERR_PC`, `ERR_ADDR`, `ERR_GRF`, `ERR_ZERO` bit indices.
- Sub-module `trace_char_class`: combinational classifier. Outputs `is_dec`, `is_hex`, and a 4-bit hex value.

## Test plan
- Clean register record: freq=4, stream `^10@00003000: $5 <= 0000000a#` gives one `rec_valid` with format 01, error 00000. `rec_count` becomes 1 and `err_count` stays 0.
- Memory record with multiple errors: freq=4, stream `^7@00003002: *00003000 <= 12345678#` gives format 10 and error 00111. `err_count` becomes 1.
- Register-file errors: `^8@00004ffc: $0 <= 00000001#` gives error 10000. `^8@00003000:$40<=00000000#` gives error 01000.
- Malformed records: 7-digit pc, uppercase `A` in data, 5 time digits, or a missing `=` each produce no `rec_valid` and leave both counters unchanged.
- Restart and stall: a `^` partway through a record restarts parsing, and the new record is reported alone. `char_valid` held low for 3 cycles in the middle of a record still yields a correct result. Reset in the middle of a record clears all outputs.
- Saturation: with CNT_W=2, five erroneous records give `rec_count`=3 and `err_count`=3.
